// File: rtl/mux_arb.sv
// N-channel arbitrating multiplexer: tag-checked inputs, fixed-priority or round-robin
// grant, registered output with valid/ready flow control and a saturating drop counter.
module mux_arb #(
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        valid_in,
    output logic [NUM_CH-1:0]        ready_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     tag_err,
    output logic [7:0]               drop_cnt
);
    localparam int TAG_W = $clog2(NUM_CH);

    logic [DATA_W-1:0] words [NUM_CH];
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] bad;
    logic [TAG_W-1:0]  gidx;
    logic [TAG_W-1:0]  ptr;
    logic              found;
    logic              slot_free;
    logic              grant;

    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic              err_p1;
    logic [7:0]        cnt_p1;

    function automatic logic [4:0] popcount(input logic [NUM_CH-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [4:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {4'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            words[i] = data_in[i*DATA_W +: DATA_W];
            elig[i]  = valid_in[i] && (words[i][DATA_W-1 -: TAG_W] == TAG_W'(i));
            bad[i]   = valid_in[i] && (words[i][DATA_W-1 -: TAG_W] != TAG_W'(i));
        end
    end

    // Fixed priority scans from 0; round-robin scans from ptr and wraps.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (RR_MODE != 0) ? (int'(ptr) + k) % NUM_CH : k;
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = TAG_W'(idx);
            end
        end
    end

    assign slot_free = !vld_p1 || ready_in;
    assign grant     = found && slot_free;

    // Bad words are always drained so a mis-tagged source can never stall the mux.
    always_comb begin
        ready_out = '0;
        if (reset_L) begin
            ready_out = bad;
            if (grant) ready_out[gidx] = 1'b1;
        end
    end

    // Stage p1: registered output word, error pulse and drop count
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            cnt_p1  <= '0;
            ptr     <= '0;
        end else begin
            if (slot_free) begin
                vld_p1 <= found;
                if (found) data_p1 <= words[gidx];
            end
            if (RR_MODE != 0 && grant) ptr <= TAG_W'((int'(gidx) + 1) % NUM_CH);
            err_p1 <= |bad;
            cnt_p1 <= sat_add(cnt_p1, popcount(bad));
        end
    end

    assign data_out  = data_p1;
    assign valid_out = vld_p1;
    assign tag_err   = err_p1;
    assign drop_cnt  = cnt_p1;
endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: one fixed-priority and one round-robin instance,
// directed vectors, forwarded words checked by a monitor against queued expectations.
module tb_mux_arb;
    logic        clk = 1'b0;
    logic        reset_l [2];
    logic [47:0] din [2];
    logic [3:0]  vin [2];
    logic [3:0]  rdy [2];
    logic [11:0] dout [2];
    logic        vout [2];
    logic        rin [2];
    logic        err [2];
    logic [7:0]  cnt [2];

    logic [11:0] q0 [$];
    logic [11:0] q1 [$];
    int total = 0;
    int bad = 0;

    logic [11:0] w4 [4] = '{12'h001, 12'h402, 12'h803, 12'hC04};
    logic [47:0] all4;

    always #5 clk = ~clk;

    mux_arb #(.DATA_W(12), .NUM_CH(4), .RR_MODE(0)) u_fp (
        .clk(clk), .reset_L(reset_l[0]), .data_in(din[0]), .valid_in(vin[0]),
        .ready_out(rdy[0]), .data_out(dout[0]), .valid_out(vout[0]),
        .ready_in(rin[0]), .tag_err(err[0]), .drop_cnt(cnt[0]));

    mux_arb #(.DATA_W(12), .NUM_CH(4), .RR_MODE(1)) u_rr (
        .clk(clk), .reset_L(reset_l[1]), .data_in(din[1]), .valid_in(vin[1]),
        .ready_out(rdy[1]), .data_out(dout[1]), .valid_out(vout[1]),
        .ready_in(rin[1]), .tag_err(err[1]), .drop_cnt(cnt[1]));

    task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h need=%0h at %0t", name, m, act, exp, $time);
        end
    endtask

    task automatic push(input int m, input logic [11:0] w);
        if (m == 0) q0.push_back(w);
        else q1.push_back(w);
    endtask

    task automatic pop_cmp(input int m);
        logic [11:0] e;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL extra_word[%0d] got=%0h need=none at %0t", m, dout[m], $time);
        end else begin
            if (m == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check("word", m, 32'(dout[m]), 32'(e));
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++)
            if (reset_l[m] === 1'b1 && vout[m] === 1'b1 && rin[m] === 1'b1) pop_cmp(m);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running need=finished");
        $fatal(1, "timeout");
    end

    initial begin
        all4 = {w4[3], w4[2], w4[1], w4[0]};
        for (int m = 0; m < 2; m++) begin
            reset_l[m] = 1'b0;
            din[m] = all4;
            vin[m] = 4'hF;
            rin[m] = 1'b1;
        end
        tick();
        tick();
        mid();
        for (int m = 0; m < 2; m++) begin
            check("rst_dout", m, 32'(dout[m]), 32'h0);
            check("rst_vout", m, 32'(vout[m]), 32'h0);
            check("rst_rdy", m, 32'(rdy[m]), 32'h0);
            check("rst_cnt", m, 32'(cnt[m]), 32'h0);
            check("rst_err", m, 32'(err[m]), 32'h0);
        end
        tick();
        reset_l[0] = 1'b1;
        reset_l[1] = 1'b1;
        vin[1] = 4'h0;
        mid();
        check("rel_rdy", 0, 32'(rdy[0]), 32'h1);
        push(0, 12'h001);
        tick();
        vin[0] = 4'h0;
        mid();
        check("rel_vout", 0, 32'(vout[0]), 32'h1);
        check("rel_rdy_idle", 0, 32'(rdy[0]), 32'h0);
        tick();

        // Fixed priority: ch1 beats ch3 until ch1 goes away
        din[0] = {12'hC12, 12'h000, 12'h4AB, 12'h000};
        vin[0] = 4'b1010;
        mid();
        check("fp_rdy1", 0, 32'(rdy[0]), 32'h2);
        push(0, 12'h4AB);
        tick();
        vin[0] = 4'b1000;
        mid();
        check("fp_rdy3", 0, 32'(rdy[0]), 32'h8);
        push(0, 12'hC12);
        tick();
        vin[0] = 4'b0000;
        mid();
        check("fp_vout", 0, 32'(vout[0]), 32'h1);
        check("fp_dout", 0, 32'(dout[0]), 32'hC12);
        tick();
        mid();
        check("fp_idle", 0, 32'(vout[0]), 32'h0);

        // Backpressure
        tick();
        vin[0] = 4'b1010;
        mid();
        check("bp_rdy1", 0, 32'(rdy[0]), 32'h2);
        push(0, 12'h4AB);
        tick();
        rin[0] = 1'b0;
        vin[0] = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("bp_vout", 0, 32'(vout[0]), 32'h1);
            check("bp_dout", 0, 32'(dout[0]), 32'h4AB);
            check("bp_rdy", 0, 32'(rdy[0]), 32'h0);
            tick();
        end
        rin[0] = 1'b1;
        mid();
        check("bp_rdy3", 0, 32'(rdy[0]), 32'h8);
        push(0, 12'hC12);
        tick();
        vin[0] = 4'b0000;
        mid();
        check("bp_next_vout", 0, 32'(vout[0]), 32'h1);
        check("bp_next_dout", 0, 32'(dout[0]), 32'hC12);
        tick();
        mid();
        check("bp_idle", 0, 32'(vout[0]), 32'h0);

        // Tag mismatch alongside a grant, then saturation
        tick();
        din[0] = {12'h000, 12'h123, 12'h000, 12'h055};
        vin[0] = 4'b0101;
        mid();
        check("tm_rdy", 0, 32'(rdy[0]), 32'h5);
        push(0, 12'h055);
        tick();
        vin[0] = 4'b0000;
        mid();
        check("tm_dout", 0, 32'(dout[0]), 32'h055);
        check("tm_err", 0, 32'(err[0]), 32'h1);
        check("tm_cnt", 0, 32'(cnt[0]), 32'h1);
        tick();
        mid();
        check("tm_err_clr", 0, 32'(err[0]), 32'h0);
        check("tm_cnt_hold", 0, 32'(cnt[0]), 32'h1);
        tick();
        vin[0] = 4'b0100;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 253) check("sat_254", 0, 32'(cnt[0]), 32'd254);
            if (i == 254) check("sat_255", 0, 32'(cnt[0]), 32'd255);
        end
        vin[0] = 4'b0000;
        mid();
        check("sat_end", 0, 32'(cnt[0]), 32'd255);
        check("sat_err", 0, 32'(err[0]), 32'h1);
        tick();
        mid();
        check("sat_hold", 0, 32'(cnt[0]), 32'd255);
        check("sat_err_clr", 0, 32'(err[0]), 32'h0);

        // Round-robin rotation over all channels
        tick();
        din[1] = all4;
        vin[1] = 4'hF;
        for (int k = 0; k < 5; k++) begin
            mid();
            check("rr_rdy", 1, 32'(rdy[1]), 32'(1 << (k % 4)));
            if (k > 0) check("rr_vout", 1, 32'(vout[1]), 32'h1);
            push(1, w4[k % 4]);
            tick();
        end
        vin[1] = 4'h0;
        mid();
        check("rr_last", 1, 32'(dout[1]), 32'h001);
        tick();
        vin[1] = 4'b1001;
        mid();
        check("rr_wrap3", 1, 32'(rdy[1]), 32'h8);
        push(1, 12'hC04);
        tick();
        mid();
        check("rr_wrap0", 1, 32'(rdy[1]), 32'h1);
        push(1, 12'h001);
        tick();
        vin[1] = 4'h0;
        mid();
        tick();

        // Reset while the output is stalled
        din[1] = {12'h000, 12'h803, 12'h000, 12'h000};
        vin[1] = 4'b0110;
        rin[1] = 1'b0;
        mid();
        check("mr_rdy", 1, 32'(rdy[1]), 32'h6);
        tick();
        vin[1] = 4'b0010;
        mid();
        check("mr_vout", 1, 32'(vout[1]), 32'h1);
        check("mr_dout", 1, 32'(dout[1]), 32'h803);
        check("mr_bad_rdy", 1, 32'(rdy[1]), 32'h2);
        check("mr_cnt", 1, 32'(cnt[1]), 32'h1);
        tick();
        reset_l[1] = 1'b0;
        din[1] = all4;
        vin[1] = 4'hF;
        mid();
        check("mr_rst_rdy", 1, 32'(rdy[1]), 32'h0);
        tick();
        mid();
        check("mr_rst_vout", 1, 32'(vout[1]), 32'h0);
        check("mr_rst_dout", 1, 32'(dout[1]), 32'h0);
        check("mr_rst_cnt", 1, 32'(cnt[1]), 32'h0);
        tick();
        reset_l[1] = 1'b1;
        rin[1] = 1'b1;
        mid();
        check("mr_first", 1, 32'(rdy[1]), 32'h1);
        push(1, 12'h001);
        tick();
        vin[1] = 4'h0;
        mid();
        tick();

        // Two bad channels in one cycle
        din[1] = {12'h123, 12'h000, 12'h000, 12'h000};
        vin[1] = 4'b1010;
        mid();
        check("pc_rdy", 1, 32'(rdy[1]), 32'hA);
        tick();
        vin[1] = 4'h0;
        mid();
        check("pc_cnt", 1, 32'(cnt[1]), 32'h2);
        check("pc_err", 1, 32'(err[1]), 32'h1);
        tick();

        check("q0_empty", 0, 32'(q0.size()), 32'h0);
        check("q1_empty", 1, 32'(q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised N-channel arbitrating multiplexer with a registered output and valid/ready handshakes on both sides. Each input channel carries words whose top bits hold a destination tag. A word is forwarded only when its tag equals the channel index. Words with a mismatched tag are consumed, discarded and counted. Sits between the per-channel source buffers and the single downstream consumer, and replaces the combinational tag mux with a flow-controlled, selectable-policy version.

## Interface

Parameters:
- DATA_W, 12, word width including tag field; must exceed TAG_W
- NUM_CH, 4, number of input channels, 2..16
- RR_MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin
- TAG_W (localparam), $clog2(NUM_CH), tag field = data[DATA_W-1 -: TAG_W]

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_L  in  1  synchronous, active-low reset
- data_in  in  NUM_CH*DATA_W  flattened channel words; channel i at [i*DATA_W +: DATA_W]
- valid_in  in  NUM_CH  per-channel word valid
- ready_out  out  NUM_CH  per-channel accept, combinational; a word on channel i is consumed on a rising edge where valid_in[i] && ready_out[i]
- data_out  out  DATA_W  registered forwarded word
- valid_out  out  1  data_out valid
- ready_in  in  1  downstream accept
- tag_err  out  1  registered one-cycle pulse: at least one mismatched word was dropped on the previous edge
- drop_cnt  out  8  saturating count of dropped words

## Operation

- Channel i is eligible when valid_in[i] && tag(data_in[i]) == i.
- Channel i is bad when valid_in[i] && tag != i. Tag values >= NUM_CH are always bad.
- Output slot is free when !valid_out || ready_in.
- Grant when the slot is free and at least one channel is eligible:
  - Select exactly one eligible channel g by the policy.
  - ready_out[g]=1; data_out <= data_in[g]; valid_out <= 1.
- No grant, slot free: valid_out <= 0; data_out holds its last value and is not cleared.
- Slot not free (valid_out && !ready_in): data_out and valid_out hold. ready_out is 0 for all eligible channels.
- Bad channels:
  - ready_out[i]=1 every cycle, independent of slot state and of any grant in the same cycle.
  - The word is never forwarded.
  - drop_cnt <= min(255, drop_cnt + popcount(bad)).
  - tag_err <= |bad.
- Fixed priority (RR_MODE=0): the lowest eligible index is granted.
- Round-robin (RR_MODE=1):
  - Pointer ptr, width TAG_W, reset 0.
  - Search eligible channels starting at ptr, ascending, wrapping modulo NUM_CH.
  - On a grant, ptr <= (g+1) mod NUM_CH. With no grant, ptr holds.
  - With RR_MODE=0, ptr is unused.
- ready_out[i] is 0 for channels with valid_in[i]=0.
- reset_L=0 has priority over all other activity:
  - data_out=0, valid_out=0, tag_err=0, drop_cnt=0, ptr=0.
  - ready_out is forced to all 0 while reset_L=0, so nothing is consumed or dropped during reset.
- Reset mid-transfer discards the held output word. No replay.

## Timing

- Latency: accept edge to valid_out=1 is 1 cycle.
- Throughput: one word per cycle while ready_in=1 and an eligible channel exists.
- ready_out is combinational from valid_in, data_in tags, valid_out, ready_in, ptr and reset_L. There is no combinational path from data_in to data_out.
- tag_err and the drop_cnt update appear on the edge after the drop.
- drop_cnt saturates at 255, stays there until reset, and never wraps.
- Simultaneous grant and drop in one cycle are both legal and independent.
- Downstream handshake: data_out and valid_out stay stable while valid_out && !ready_in.

## Test plan

All scenarios use defaults DATA_W=12, NUM_CH=4.

1. Reset: reset_L=0 for 2 cycles with all four channels valid and tagged correctly -> data_out=0x000, valid_out=0, ready_out=4'b0000, drop_cnt=0, tag_err=0; first grant 1 cycle after release.
2. Fixed priority, RR_MODE=0, ready_in=1: ch1=0x4AB and ch3=0xC12 valid and held -> ready_out=4'b0010, next cycle data_out=0x4AB; source then drops valid_in[1] -> ready_out=4'b1000, data_out=0xC12 one cycle later.
3. Round-robin, RR_MODE=1: all channels continuously valid with correct tags (0x001, 0x402, 0x803, 0xC04), ready_in=1 -> data_out sequence 0x001, 0x402, 0x803, 0xC04, 0x001, one per cycle.
4. Backpressure: valid_out=1 with data_out=0x4AB, ready_in=0 for 3 cycles -> data_out and valid_out stable, eligible ready_out bits 0; raise ready_in -> next word follows 1 cycle later with no gap or duplicate.
5. Tag mismatch: ch2=0x123 (tag 0) valid for 1 cycle, concurrently ch0=0x055 valid -> ready_out=4'b0101, data_out=0x055, tag_err pulses 1 cycle, drop_cnt=1. Then 300 bad words -> drop_cnt=255 and holds.
6. Reset mid-operation: assert reset_L=0 while valid_out=1 and ready_in=0 -> next edge valid_out=0, data_out=0, ptr=0; after release, channel 0 is granted first in RR_MODE=1.
